// File: rtl/opb_register_simulink2ppc.sv
// opb_register_simulink2ppc
//
// Publishes one 32-bit word from fabric user logic to the PowerPC as a
// small OPB slave register map. User logic strobes a word in; the block
// latches it and tracks freshness (NEW), lost words (OVERRUN), a capture
// count (CNT) and a software-controlled FREEZE that drops strobes.
// Everything runs on OPB_Clk; user logic must be synchronous to it.
//
// Register map (word offsets within the 256-byte window):
//   0x00 DATA    RO  last captured word; a read clears NEW
//   0x04 STATUS  RO  {CNT[15:0], 13'b0, FREEZE, OVERRUN, NEW}
//   0x08 CONTROL RW  write bit0 = CLEAR pulse, bit1 = FREEZE (needs BE[3])
//   others           read 0, writes ignored, always acked
//
// Ports:
//   OPB_Clk, OPB_Rst        clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW    OPB request (big-endian bit numbering)
//   OPB_select, OPB_seqAddr transfer request, sequential hint (unused)
//   Sl_DBus, Sl_xferAck     registered read data and acknowledge
//   Sl_errAck/retry/toutSup tied low
//   user_data_in/en         word to publish and its capture strobe
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a selected, in-window request; latch request
// DECODE | snapshot read data into the holding register; abort if
//        | select has dropped
// ACK    | ack goes out next cycle; writes / NEW-clear applied on exit

module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter logic [55:0] C_FAMILY     = "virtex5"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    input  logic [31:0]                 user_data_in,
    input  logic                        user_data_en
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t state_q, state_d;

    // latched request
    logic [5:0]  off_q;
    logic        rnw_q;
    logic        be3_q;
    logic [1:0]  wd_q;

    logic [31:0] hold_q;
    logic [31:0] dbus_q;
    logic        ack_q;

    // published register state
    logic [31:0] data_q;
    logic        new_q;
    logic        overrun_q;
    logic        freeze_q;
    logic [15:0] cnt_q;

    logic [C_OPB_AWIDTH-1:0] addr_rel;
    logic        hit;
    logic        cap;
    logic        ctl_wr;
    logic        do_clear;
    logic        rd_clr;
    logic [31:0] rd_word;
    logic        unused_ok;

    // Single unsigned compare covers both window bounds.
    assign addr_rel = OPB_ABus - C_BASEADDR;
    assign hit      = (addr_rel <= (C_HIGHADDR - C_BASEADDR));

    assign cap      = user_data_en && !freeze_q;
    assign ctl_wr   = (state_q == ACK) && !rnw_q && (off_q == 6'd2) && be3_q;
    assign do_clear = ctl_wr && wd_q[0];
    assign rd_clr   = (state_q == ACK) && rnw_q && (off_q == 6'd0);

    assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29], C_FAMILY};

    always_comb begin
        rd_word = '0;
        case (off_q)
            6'd0:    rd_word = data_q;
            6'd1:    rd_word = {cnt_q, 13'b0, freeze_q, overrun_q, new_q};
            6'd2:    rd_word = {30'b0, freeze_q, 1'b0};
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (OPB_select && hit) state_d = DECODE;
            DECODE:  state_d = OPB_select ? ACK : IDLE;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q   <= IDLE;
            off_q     <= '0;
            rnw_q     <= 1'b0;
            be3_q     <= 1'b0;
            wd_q      <= '0;
            hold_q    <= '0;
            dbus_q    <= '0;
            ack_q     <= 1'b0;
            data_q    <= '0;
            new_q     <= 1'b0;
            overrun_q <= 1'b0;
            freeze_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && OPB_select && hit) begin
                off_q <= OPB_ABus[24:29];
                rnw_q <= OPB_RNW;
                be3_q <= OPB_BE[3];
                wd_q  <= OPB_DBus[30:31];
            end

            if (state_q == DECODE && OPB_select)
                hold_q <= rd_word;

            // Ack and data are registered off the ACK state, so they appear
            // in the cycle after ACK and never two cycles in a row.
            ack_q  <= (state_q == ACK);
            dbus_q <= (state_q == ACK && rnw_q) ? hold_q : '0;

            if (cap)
                data_q <= user_data_in;

            // A capture outranks the DATA-read clear of NEW.
            if (cap)
                new_q <= 1'b1;
            else if (rd_clr)
                new_q <= 1'b0;

            // CLEAR outranks a simultaneous capture for OVERRUN and CNT.
            if (do_clear)
                overrun_q <= 1'b0;
            else if (cap && new_q)
                overrun_q <= 1'b1;

            if (do_clear)
                cnt_q <= '0;
            else if (cap)
                cnt_q <= cnt_q + 16'd1;

            if (ctl_wr)
                freeze_q <= wd_q[1];
        end
    end

    assign Sl_DBus    = dbus_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
module tb_opb_register_simulink2ppc;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in;
    logic        user_data_en;

    int n_chk  = 0;
    int n_fail = 0;

    opb_register_simulink2ppc dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst      (OPB_Rst),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_in (user_data_in),
        .user_data_en (user_data_en)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives at negedges; lat counts negedges after select, so an ack two
    // cycles after the sampling edge shows up at lat = 3.
    task automatic xfer(input logic [31:0] addr, input logic rnw,
                        input logic [3:0] be, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic acked,
                        output int lat);
        rdata = '0;
        acked = 1'b0;
        lat   = 0;
        @(negedge OPB_Clk);
        OPB_ABus   = addr;
        OPB_RNW    = rnw;
        OPB_BE     = be;
        OPB_DBus   = wdata;
        OPB_select = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge OPB_Clk);
            if (Sl_xferAck) begin
                rdata = Sl_DBus;
                acked = 1'b1;
                lat   = k;
                break;
            end
        end
        OPB_select = 1'b0;
        OPB_DBus   = '0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr,
                      input logic [31:0] exp);
        logic [31:0] d;
        logic        a;
        int          l;
        xfer(addr, 1'b1, 4'hF, 32'h0, d, a, l);
        check_val({tag, "_ack"}, {31'b0, a}, 32'd1);
        check_val(tag, d, exp);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] be);
        logic [31:0] d;
        logic        a;
        int          l;
        xfer(addr, 1'b0, be, data, d, a, l);
        check_val({tag, "_ack"}, {31'b0, a}, 32'd1);
    endtask

    task automatic capture(input logic [31:0] d);
        @(negedge OPB_Clk);
        user_data_in = d;
        user_data_en = 1'b1;
        @(negedge OPB_Clk);
        user_data_en = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        a;
        int          l;
        int          n_ack;
        int          n_b2b;
        logic        prev;

        OPB_Rst      = 1'b1;
        OPB_ABus     = '0;
        OPB_BE       = '0;
        OPB_DBus     = '0;
        OPB_RNW      = 1'b0;
        OPB_select   = 1'b0;
        OPB_seqAddr  = 1'b0;
        user_data_in = '0;
        user_data_en = 1'b0;
        repeat (3) @(negedge OPB_Clk);
        check_val("rst_ack", {31'b0, Sl_xferAck}, 32'd0);
        check_val("rst_dbus", Sl_DBus, 32'h0);
        OPB_Rst = 1'b0;

        // reset contents and ack latency
        xfer(32'h0, 1'b1, 4'hF, 32'h0, d, a, l);
        check_val("rst_data", d, 32'h0);
        check_val("ack_latency", l, 3);
        rd("rst_status", 32'h4, 32'h0);

        // single capture, NEW cleared by DATA read
        capture(32'hDEADBEEF);
        rd("status_new", 32'h4, 32'h0001_0001);
        rd("data_beef", 32'h0, 32'hDEADBEEF);
        rd("status_read", 32'h4, 32'h0001_0000);

        // overrun and CLEAR
        wr("clr0", 32'h8, 32'h1, 4'hF);
        capture(32'h1);
        capture(32'h2);
        capture(32'h3);
        rd("status_ovr", 32'h4, 32'h0003_0003);
        wr("clr1", 32'h8, 32'h1, 4'hF);
        rd("status_clr", 32'h4, 32'h0000_0001);
        rd("data_3", 32'h0, 32'h3);
        rd("status_idle", 32'h4, 32'h0);

        // FREEZE drops strobes
        wr("frz_on", 32'h8, 32'h2, 4'hF);
        rd("ctrl_frz", 32'h8, 32'h2);
        @(negedge OPB_Clk);
        user_data_in = 32'h55;
        user_data_en = 1'b1;
        repeat (5) @(negedge OPB_Clk);
        user_data_en = 1'b0;
        rd("status_frz", 32'h4, 32'h0000_0004);
        rd("data_frz", 32'h0, 32'h3);
        wr("frz_off", 32'h8, 32'h0, 4'hF);
        capture(32'h77);
        rd("status_unfrz", 32'h4, 32'h0001_0001);
        rd("data_77", 32'h0, 32'h77);
        rd("unmapped", 32'h0C, 32'h0);

        // capture on the ACK->IDLE edge of a DATA read
        capture(32'hA1);
        @(negedge OPB_Clk);
        OPB_ABus   = 32'h0;
        OPB_RNW    = 1'b1;
        OPB_BE     = 4'hF;
        OPB_select = 1'b1;
        @(negedge OPB_Clk);
        @(negedge OPB_Clk);
        user_data_in = 32'hB2;
        user_data_en = 1'b1;
        @(negedge OPB_Clk);
        user_data_en = 1'b0;
        check_val("same_edge_ack", {31'b0, Sl_xferAck}, 32'd1);
        check_val("same_edge_old", Sl_DBus, 32'hA1);
        OPB_select = 1'b0;
        rd("same_edge_status", 32'h4, 32'h0003_0003);
        rd("same_edge_data", 32'h0, 32'hB2);

        // BE[3] = 0 write has no effect
        wr("be0", 32'h8, 32'h2, 4'h0);
        rd("ctrl_be0", 32'h8, 32'h0);
        rd("status_be0", 32'h4, 32'h0003_0002);

        // held select: back-to-back transfers, acks never adjacent
        @(negedge OPB_Clk);
        OPB_ABus   = 32'h4;
        OPB_RNW    = 1'b1;
        OPB_BE     = 4'hF;
        OPB_select = 1'b1;
        n_ack = 0;
        n_b2b = 0;
        prev  = 1'b0;
        repeat (7) begin
            @(negedge OPB_Clk);
            if (Sl_xferAck) n_ack++;
            if (Sl_xferAck && prev) n_b2b++;
            prev = Sl_xferAck;
        end
        OPB_select = 1'b0;
        repeat (3) @(negedge OPB_Clk);
        check_val("held_acks", n_ack, 2);
        check_val("held_b2b", n_b2b, 0);

        // select dropped in DECODE: no ack, CLEAR not applied
        @(negedge OPB_Clk);
        OPB_ABus   = 32'h8;
        OPB_RNW    = 1'b0;
        OPB_BE     = 4'hF;
        OPB_DBus   = 32'h1;
        OPB_select = 1'b1;
        @(negedge OPB_Clk);
        OPB_select = 1'b0;
        n_ack = 0;
        repeat (5) begin
            @(negedge OPB_Clk);
            if (Sl_xferAck) n_ack++;
        end
        check_val("abort_ack", n_ack, 0);
        check_val("abort_dbus", Sl_DBus, 32'h0);
        rd("abort_status", 32'h4, 32'h0003_0002);

        // reset during DECODE
        @(negedge OPB_Clk);
        OPB_ABus   = 32'h8;
        OPB_RNW    = 1'b0;
        OPB_DBus   = 32'h2;
        OPB_select = 1'b1;
        @(negedge OPB_Clk);
        OPB_Rst = 1'b1;
        @(negedge OPB_Clk);
        OPB_Rst    = 1'b0;
        OPB_select = 1'b0;
        n_ack = 0;
        repeat (5) begin
            @(negedge OPB_Clk);
            if (Sl_xferAck) n_ack++;
        end
        check_val("rstmid_ack", n_ack, 0);
        check_val("rstmid_dbus", Sl_DBus, 32'h0);
        rd("rstmid_status", 32'h4, 32'h0);
        rd("rstmid_data", 32'h0, 32'h0);
        rd("rstmid_ctrl", 32'h8, 32'h0);

        // out-of-window address
        xfer(32'h100, 1'b1, 4'hF, 32'h0, d, a, l);
        check_val("oow_ack", {31'b0, a}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc.md
# opb_register_simulink2ppc

Read-back register carrying one 32-bit word from fabric user logic to the PowerPC over the OPB bus; the reverse direction of the PPC-to-fabric software register. User logic presents a word with a capture strobe. The block latches it, tracks freshness, overrun and update count, and serves these as a small OPB slave register map. It runs in the OPB clock domain, and user logic driving it must be synchronous to OPB_Clk.

## Interface
- C_BASEADDR, 32'h00000000, first byte address of the 256-byte window
- C_HIGHADDR, 32'h000000FF, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_FAMILY, "virtex5", target family (informational)

Ports:
- OPB_Clk  in  1  sole clock; all logic rising-edge
- OPB_Rst  in  1  reset, synchronous, active-high
- OPB_ABus  in  [0:31]  byte address
- OPB_BE  in  [0:3]  byte enables; OPB_BE[3] covers OPB_DBus[24:31]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; all zero whenever Sl_xferAck = 0 (OR-bus rule)
- Sl_xferAck  out  1  single-cycle transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- user_data_in  in  [31:0]  word to publish
- user_data_en  in  1  capture strobe, one cycle per word

## Operation
- Bit numbering: register field bit k (LSB = 0) maps to Sl_DBus[31-k] and OPB_DBus[31-k].
- Address hit: C_BASEADDR <= OPB_ABus <= C_HIGHADDR. The offset is OPB_ABus[24:29] × 4.
- Register map:
  - 0x00 DATA (RO): last captured word. A read clears NEW.
  - 0x04 STATUS (RO): [0] NEW, [1] OVERRUN, [2] FREEZE, [15:3] zero, [31:16] CNT (16-bit count of accepted captures).
  - 0x08 CONTROL (R/W, reads return {30'b0, FREEZE, 1'b0}). A write with OPB_BE[3] = 1 acts on bits [1:0]:
    - bit0 = 1 pulses CLEAR: OVERRUN = 0, CNT = 0.
    - bit1 sets FREEZE.
    - If OPB_BE[3] = 0, the write is acked and has no effect.
  - 0x0C–0xFC: reads return 0, writes are ignored, both are acked.
  - Writes to DATA or STATUS are acked and ignored.
- Capture: when user_data_en = 1 and FREEZE = 0:
  - DATA takes user_data_in.
  - CNT increments and wraps 0xFFFF -> 0x0000.
  - NEW = 1.
  - If NEW was already 1 before this edge, OVERRUN = 1 (sticky).
- While FREEZE = 1, strobes are dropped entirely: DATA, CNT, NEW and OVERRUN are unchanged.
- Bus FSM:
  - IDLE: go to DECODE when OPB_select = 1 and the address hits. Latch offset, RNW, BE and write data.
  - DECODE: form read data from the current registers into a holding register, then go to ACK.
  - ACK: Sl_xferAck = 1 and Sl_DBus = holding register (reads) or zero (writes). Writes and NEW-clear take effect at the ACK→IDLE edge. Go to IDLE unconditionally.
  - If OPB_select drops while in DECODE, abort to IDLE with no ack and no side effects.
- Simultaneous events:
  - Capture and DATA-read NEW-clear on the same edge: capture wins, so NEW = 1. The read returns the pre-capture word.
  - Capture and CLEAR on the same edge: CLEAR wins for CNT (0) and OVERRUN (0); DATA and NEW are updated by the capture.

## Timing
- Reset values: Sl_xferAck 0, Sl_DBus 0, DATA 0, NEW 0, OVERRUN 0, FREEZE 0, CNT 0, FSM IDLE.
- Reset mid-transaction returns the FSM to IDLE with no ack issued.
- Ack latency: OPB_select first sampled high at edge N, Sl_xferAck high for exactly the cycle between edges N+2 and N+3.
- Sl_xferAck is never high two cycles in a row.
- If select is still high in the IDLE cycle after ACK, it is a new transfer.
- Capture latency: a strobe at edge N is visible in the DECODE snapshot at any edge ≥ N+1.
- STATUS reflects captures up to and including the DECODE edge.
- All outputs are registered; there are no combinational paths from OPB inputs to Sl_* outputs.

## Test plan
- Reset, then read 0x00 and 0x04: both return 0x00000000, and ack arrives 2 cycles after select.
- Capture 0xDEADBEEF, read 0x04, read 0x00, read 0x04:
  - first STATUS = 0x00010001;
  - DATA = 0xDEADBEEF;
  - second STATUS = 0x00010000.
- Three captures (0x1, 0x2, 0x3) with no read: STATUS = 0x00030003 and DATA = 0x3. Then write 0x08 = 0x1: STATUS = 0x00000001.
- Write 0x08 = 0x2, strobe 0x55 five times: DATA, CNT and NEW are unchanged and STATUS bit2 = 1. Write 0x08 = 0x0, then a capture is accepted.
- Capture on the same edge as the DATA-read clear (ACK→IDLE edge): NEW stays 1 and the read returns the old word. Also check that OPB_BE = 4'b0000 write to 0x08 = 0x2 leaves FREEZE = 0.
- Select deasserted during DECODE, and OPB_Rst asserted during DECODE: no Sl_xferAck, Sl_DBus stays 0, and registers are unchanged or reset respectively. An out-of-window address gives no ack.
